// File: rtl/wb_trace_uart.sv
// Register-writeback trace transmitter: captures non-x0 writebacks into a FIFO
// and sends each as a 6-byte 8N1 UART frame (A5, reg, data MSB first).
module wb_trace_uart #(
    parameter int unsigned BAUD_DIV  = 200,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [4:0]           wb_write_reg,
    input  logic [31:0]          wb_write_data,
    input  logic                 enable,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]      BAUD_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [FIFO_LOG2:0] FULL_LVL    = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [36:0]          mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   level_q, level_d;
    logic                 overflow_q;

    state_t               state_q;
    logic [47:0]          frame_q;
    logic [CW-1:0]        baud_q;
    logic [2:0]           bit_idx_q;
    logic [2:0]           byte_idx_q;
    logic                 tx_q;

    logic                 push_req, full, pop, push_ok;
    logic [36:0]          rd_entry;
    logic [7:0]           cur_byte;

    always_comb begin
        push_req = enable && wb_we && (wb_write_reg != '0);
        full     = (level_q == FULL_LVL);
        pop      = (state_q == IDLE) && (level_q != '0);
        // A pop in the same cycle frees a slot, so a push at full is still taken.
        push_ok  = push_req && (!full || pop);
        level_d  = level_q;
        if (push_ok && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push_ok)
            level_d = level_q - 1'b1;
        rd_entry = mem_q[rd_ptr_q];
    end

    assign cur_byte = frame_q[47:40];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {wb_write_reg, wb_write_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            if (push_req && !push_ok)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= BAUD_RELOAD;
                    if (pop) begin
                        frame_q    <= {8'hA5, 3'b000, rd_entry};
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_q == '0) begin
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_RELOAD;
                        if (byte_idx_q == 3'd5) begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            // Next byte moves into the top of the shift register; no idle gap.
                            byte_idx_q <= byte_idx_q + 3'd1;
                            frame_q    <= {frame_q[39:0], 8'h00};
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || (level_q != '0);
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule
